// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-cycle grant latency, a grant held until done, the owner drops its request, or HOLD_MAX cycles elapse.
// Every release costs one IDLE cycle; the priority pointer advances past the released owner.
module round_robin_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BIN_W    = $clog2(NUM_REQ),
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [BIN_W-1:0]   gnt_id_o,
  output logic               gnt_valid_o,
  output logic               timeout_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t           state;
  logic [BIN_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [BIN_W-1:0] sel_id;
  logic             sel_found;
  logic             owner_req;
  logic             hold_hit;
  logic             release_now;

  // Search starts at ptr and wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [BIN_W-1:0] idx;
      idx = ptr + BIN_W'(i);
      if (!sel_found && req_i[idx]) begin
        sel_id    = idx;
        sel_found = 1'b1;
      end
    end
  end

  assign owner_req   = req_i[gnt_id_o];
  assign hold_hit    = (hold_cnt == HOLD_LAST);
  assign release_now = done_i || !owner_req || hold_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_o       <= '0;
      gnt_id_o    <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_o <= 1'b0;
          if (sel_found) begin
            state       <= BUSY;
            hold_cnt    <= '0;
            gnt_id_o    <= sel_id;
            gnt_o       <= NUM_REQ'(1) << sel_id;
            gnt_valid_o <= 1'b1;
          end
        end
        BUSY: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (release_now) begin
            state       <= IDLE;
            ptr         <= gnt_id_o + BIN_W'(1);
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
            // Only a pure hold-limit release counts as a timeout.
            timeout_o   <= hold_hit && !done_i && owner_req;
          end else begin
            timeout_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          gnt_o       <= '0;
          gnt_valid_o <= 1'b0;
          timeout_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (power of two, 2..16).
REQ-002 The block SHALL have parameter BIN_W, default $clog2(NUM_REQ), width of the binary grant index.
REQ-003 The block SHALL have parameter HOLD_MAX, default 8, maximum cycles a grant is held (1..255).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_i  input  NUM_REQ  per-requester request, bit k = requester k.
REQ-007 The block SHALL have port done_i  input  1  current owner releases the resource.
REQ-008 The block SHALL have port gnt_o  output  NUM_REQ  one-hot grant, registered.
REQ-009 The block SHALL have port gnt_id_o  output  BIN_W  binary index of the owner, registered.
REQ-010 The block SHALL have port gnt_valid_o  output  1  high while any grant is active.
REQ-011 The block SHALL have port timeout_o  output  1  one-cycle pulse on forced release at HOLD_MAX.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-013 The block SHALL keep a BIN_W-bit priority pointer ptr; search order is ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-014 In IDLE with req_i != 0, the block SHALL select the first asserted requester in search order and enter BUSY at the next edge.
REQ-015 Grant latency SHALL be one cycle: req_i sampled at edge k gives gnt_o/gnt_id_o/gnt_valid_o valid after edge k.
REQ-016 In IDLE with req_i == 0, outputs SHALL stay zero and ptr SHALL not change.
REQ-017 gnt_o SHALL always equal (1 << gnt_id_o) when gnt_valid_o=1 and all-zero otherwise; never more than one bit set.
REQ-018 On grant entry the block SHALL clear an 8-bit hold counter; each BUSY cycle SHALL increment it.
REQ-019 In BUSY the block SHALL release at the next edge when any of: done_i=1; req_i[owner]=0; hold counter == HOLD_MAX-1.
REQ-020 On release the block SHALL set ptr = (owner+1) mod NUM_REQ, clear gnt_o/gnt_valid_o, and return to IDLE.
REQ-021 gnt_id_o SHALL hold the last owner's index after release (not cleared) until the next grant.
REQ-022 Every release SHALL be followed by at least one IDLE cycle; no back-to-back grants.
REQ-023 timeout_o SHALL pulse for exactly the cycle after a release caused only by the hold limit (done_i=0 and req_i[owner]=1).
REQ-024 Simultaneous done_i and hold limit SHALL count as a done release; timeout_o stays 0.
REQ-025 done_i in IDLE SHALL be ignored.
REQ-026 Requests from non-owners during BUSY SHALL not affect the grant; they are evaluated only in IDLE.
REQ-027 Pointer wrap: owner NUM_REQ-1 SHALL set ptr to 0.

Reset
REQ-028 On reset_n=0, the block SHALL immediately (asynchronously) set gnt_o=0, gnt_id_o=0, gnt_valid_o=0, timeout_o=0, ptr=0, hold counter=0, state IDLE.
REQ-029 Reset asserted mid-grant SHALL drop the grant without a timeout pulse; after deassertion arbitration restarts from ptr=0.

Verification (NUM_REQ=4, HOLD_MAX=8)
REQ-030 Reset then req_i=4'b0000 for 5 cycles -> gnt_o=0, gnt_valid_o=0, gnt_id_o=0 throughout.
REQ-031 Reset, req_i=4'b1010 held, done_i pulsed 2 cycles after each grant -> grants 1, 3, 1, 3 in order, each separated by one IDLE cycle.
REQ-032 Reset, req_i=4'b1111 held, done_i after 1 cycle each -> gnt_o sequence 0001, 0010, 0100, 1000, 0001 (wrap).
REQ-033 Reset, req_i=4'b0100 held, done_i=0 -> gnt_o=0100 for exactly 8 cycles, timeout_o pulses once, then re-grant to 2 after one IDLE cycle.
REQ-034 Grant to requester 2, then req_i[2] dropped -> gnt_o=0 next cycle, ptr=3, timeout_o=0.
REQ-035 reset_n pulsed low while gnt_o=0100 -> outputs zero asynchronously; after release with req_i=4'b1100 -> next grant is 2.
